pcie_turnoff_init: RTL and testbench



---
 rtl/pcie_turnoff_init.sv | 111 +++++++++++
 tb/tb_pcie_turnoff_init.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_turnoff_init.sv
// Root-port initiator for the PME_Turn_Off / PME_TO_Ack handshake: drains outstanding
// traffic, strobes the core, waits for the ack with timeout/retry, reports done or error.
module pcie_turnoff_init #(
  parameter int unsigned                TMO_W     = 20,
  parameter logic [TMO_W-1:0]           TMO_VAL   = 20'd1000000,
  parameter int unsigned                RETRY_W   = 2,
  parameter logic [RETRY_W-1:0]         MAX_RETRY = 2'd3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               turnoff_req_i,
  input  logic               trn_pending_i,
  output logic               cfg_pm_send_pme_to_n_o,
  input  logic               cfg_msg_pme_to_ack_i,
  output logic               turnoff_busy_o,
  output logic               turnoff_done_o,
  output logic               turnoff_err_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_VAL - 1'b1;

  state_t             state_reg, state_next;
  logic [TMO_W-1:0]   timer_reg, timer_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic               send_n_reg, send_n_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      timer_reg  <= '0;
      retry_reg  <= '0;
      send_n_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      retry_reg  <= retry_next;
      send_n_reg <= send_n_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    retry_next = retry_reg;
    case (state_reg)
      S_IDLE: begin
        if (turnoff_req_i) begin
          state_next = S_DRAIN;
          retry_next = '0;
        end
      end
      S_DRAIN: begin
        if (!trn_pending_i) state_next = S_SEND;
      end
      S_SEND: begin
        timer_next = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        timer_next = timer_reg + 1'b1;
        // Ack takes priority over a timeout landing in the same cycle
        if (cfg_msg_pme_to_ack_i) begin
          state_next = S_DONE;
        end else if (timer_reg == TMO_LAST) begin
          if (retry_reg == MAX_RETRY) begin
            state_next = S_ERR;
          end else begin
            retry_next = retry_reg + 1'b1;
            state_next = S_SEND;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!turnoff_req_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it
    send_n_next = (state_next != S_SEND);
    busy_next   = (state_next == S_DRAIN) || (state_next == S_SEND) || (state_next == S_WAIT);
    done_next   = (state_next == S_DONE);
    err_next    = (state_next == S_ERR);
  end

  assign cfg_pm_send_pme_to_n_o = send_n_reg;
  assign turnoff_busy_o         = busy_reg;
  assign turnoff_done_o         = done_reg;
  assign turnoff_err_o          = err_reg;
  assign retry_cnt_o            = retry_reg;

endmodule

// File: tb/tb_pcie_turnoff_init.sv
// Directed bench for pcie_turnoff_init with a short ack timeout (16 cycles, 3 retries).
module tb_pcie_turnoff_init;
  localparam int unsigned TMO_W     = 20;
  localparam logic [19:0] TMO_VAL   = 20'd16;
  localparam int unsigned RETRY_W   = 2;
  localparam logic [1:0]  MAX_RETRY = 2'd3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               turnoff_req_i = 1'b0;
  logic               trn_pending_i = 1'b0;
  logic               cfg_msg_pme_to_ack_i = 1'b0;
  logic               cfg_pm_send_pme_to_n_o;
  logic               turnoff_busy_o;
  logic               turnoff_done_o;
  logic               turnoff_err_o;
  logic [RETRY_W-1:0] retry_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;

  pcie_turnoff_init #(
    .TMO_W(TMO_W), .TMO_VAL(TMO_VAL), .RETRY_W(RETRY_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .turnoff_req_i(turnoff_req_i),
    .trn_pending_i(trn_pending_i),
    .cfg_pm_send_pme_to_n_o(cfg_pm_send_pme_to_n_o),
    .cfg_msg_pme_to_ack_i(cfg_msg_pme_to_ack_i),
    .turnoff_busy_o(turnoff_busy_o),
    .turnoff_done_o(turnoff_done_o),
    .turnoff_err_o(turnoff_err_o),
    .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  // Each low strobe cycle is counted once, at the edge that ends it
  always @(posedge clk) if (cfg_pm_send_pme_to_n_o === 1'b0) strobe_cnt <= strobe_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_strobe(input int budget, input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cfg_pm_send_pme_to_n_o !== 1'b0 && n < budget);
    check_eq({tag, "_seen"}, {31'd0, cfg_pm_send_pme_to_n_o}, 32'd0);
  endtask

  task automatic pulse_ack();
    cfg_msg_pme_to_ack_i = 1'b1;
    step();
    cfg_msg_pme_to_ack_i = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic sn, input logic b, input logic d,
                            input logic e, input logic [1:0] r);
    check_eq({tag, "_send_n"}, {31'd0, cfg_pm_send_pme_to_n_o}, {31'd0, sn});
    check_eq({tag, "_busy"},   {31'd0, turnoff_busy_o},         {31'd0, b});
    check_eq({tag, "_done"},   {31'd0, turnoff_done_o},         {31'd0, d});
    check_eq({tag, "_err"},    {31'd0, turnoff_err_o},          {31'd0, e});
    check_eq({tag, "_retry"},  {30'd0, retry_cnt_o},            {30'd0, r});
  endtask

  initial begin
    int n;
    int s0;

    // Reset state
    step(2);
    check_outs("rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    step();
    check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    $display("seq reset: checked reset and idle outputs");

    // 1: basic handshake, ack about 5 cycles after the strobe
    s0 = strobe_cnt;
    turnoff_req_i = 1'b1;
    step();
    check_outs("t1_drain", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    step();
    check_eq("t1_strobe_lat", {31'd0, cfg_pm_send_pme_to_n_o}, 32'd0);
    step();
    check_eq("t1_strobe_1cyc", {31'd0, cfg_pm_send_pme_to_n_o}, 32'd1);
    step(3);
    check_eq("t1_pre_ack_done", {31'd0, turnoff_done_o}, 32'd0);
    pulse_ack();
    check_outs("t1_done", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    check_eq("t1_strobes", strobe_cnt - s0, 32'd1);
    turnoff_req_i = 1'b0;
    step();
    check_outs("t1_release", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    $display("seq 1: single send, ack received");

    // 2: drain holds off the strobe while pending
    s0 = strobe_cnt;
    trn_pending_i = 1'b1;
    turnoff_req_i = 1'b1;
    step(40);
    check_eq("t2_no_strobe", strobe_cnt - s0, 32'd0);
    check_eq("t2_busy", {31'd0, turnoff_busy_o}, 32'd1);
    trn_pending_i = 1'b0;
    step();
    check_eq("t2_strobe_after_drain", {31'd0, cfg_pm_send_pme_to_n_o}, 32'd0);
    step(2);
    pulse_ack();
    check_outs("t2_done", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    turnoff_req_i = 1'b0;
    step();
    $display("seq 2: drain wait then ack");

    // 3: two timeouts, ack in the third attempt
    s0 = strobe_cnt;
    turnoff_req_i = 1'b1;
    wait_strobe(5, "t3_s1", n);
    check_eq("t3_s1_lat", n, 32'd2);
    wait_strobe(30, "t3_s2", n);
    check_eq("t3_gap1", n, 32'd17);
    check_eq("t3_retry1", {30'd0, retry_cnt_o}, 32'd1);
    wait_strobe(30, "t3_s3", n);
    check_eq("t3_gap2", n, 32'd17);
    step(3);
    pulse_ack();
    check_outs("t3_done", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    check_eq("t3_strobes", strobe_cnt - s0, 32'd3);
    turnoff_req_i = 1'b0;
    step();
    $display("seq 3: ack on third attempt");

    // 4: no ack at all -> error after four sends
    s0 = strobe_cnt;
    turnoff_req_i = 1'b1;
    wait_strobe(5, "t4_s1", n);
    for (int k = 2; k <= 4; k++) begin
      wait_strobe(30, "t4_sn", n);
      check_eq("t4_gap", n, 32'd17);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (turnoff_err_o !== 1'b1 && n < 30);
    check_eq("t4_err_lat", n, 32'd17);
    check_outs("t4_err", 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
    step(5);
    check_eq("t4_strobes", strobe_cnt - s0, 32'd4);
    pulse_ack();
    check_outs("t4_ack_in_err", 1'b1, 1'b0, 1'b0, 1'b1, 2'd3);
    turnoff_req_i = 1'b0;
    step();
    check_outs("t4_release", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    step(2);
    check_eq("t4_stays_idle", {31'd0, turnoff_busy_o}, 32'd0);
    $display("seq 4: no ack, error reported");

    // 5: idle ack ignored, ack in SEND ignored, ack coincident with timeout wins
    pulse_ack();
    check_outs("t5_idle_ack", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    s0 = strobe_cnt;
    turnoff_req_i = 1'b1;
    wait_strobe(5, "t5_s1", n);
    pulse_ack();
    check_outs("t5_send_ack", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    step(15);
    pulse_ack();
    check_outs("t5_tmo_ack", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    step(20);
    check_eq("t5_strobes", strobe_cnt - s0, 32'd1);
    turnoff_req_i = 1'b0;
    step();
    $display("seq 5: stray acks ignored, ack beats timeout");

    // 6: asynchronous reset in mid-wait after one retry
    turnoff_req_i = 1'b1;
    wait_strobe(5, "t6_s1", n);
    wait_strobe(30, "t6_s2", n);
    step(3);
    check_eq("t6_pre_rst_retry", {30'd0, retry_cnt_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_outs("t6_async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(2);
    rst_n = 1'b1;
    wait_strobe(5, "t6_restart", n);
    check_eq("t6_restart_lat", n, 32'd2);
    check_outs("t6_restart", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step(2);
    pulse_ack();
    check_outs("t6_done", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    turnoff_req_i = 1'b0;
    step();
    $display("seq 6: async reset abort and restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
